// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: FSM state
// encodings, access width codes and the registered bus request record.
package mem_port_arbiter_pkg;

  // Arbiter FSM states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  // Access width codes, matching funct3[1:0] of loads/stores.
  localparam logic [1:0] MEM_W_B = 2'd0;
  localparam logic [1:0] MEM_W_H = 2'd1;
  localparam logic [1:0] MEM_W_W = 2'd2;

  // Everything that is held stable on the memory bus for one transaction.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [1:0]  width;
  } mem_req_t;

  // An instruction fetch is always a full-word read with no store data.
  function automatic mem_req_t fetch_req(input logic [31:0] addr);
    mem_req_t r;
    r.addr  = addr;
    r.wdata = 32'd0;
    r.write = 1'b0;
    r.width = MEM_W_W;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and the
// load/store port. One transaction at a time; data has priority, bounded by
// a starvation counter so a waiting fetch is eventually served. A taken jump
// (flush_i) silences the response of an in-flight fetch without aborting it.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        ireq_valid_i,
  output logic        ireq_ready_o,
  input  logic [31:0] ireq_addr_i,
  output logic        irsp_valid_o,
  output logic [31:0] irsp_data_o,
  input  logic        flush_i,

  input  logic        dreq_valid_i,
  output logic        dreq_ready_o,
  input  logic [31:0] dreq_addr_i,
  input  logic [31:0] dreq_wdata_i,
  input  logic        dreq_write_i,
  input  logic [1:0]  dreq_width_i,
  output logic        drsp_valid_o,
  output logic [31:0] drsp_data_o,

  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_o,
  output logic [1:0]  mem_width_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]  state_reg,      state_next;
  logic [3:0]  starve_cnt_reg, starve_cnt_next;
  logic        drop_reg,       drop_next;
  mem_req_t    bus_reg,        bus_next;
  logic        mem_req_reg,    mem_req_next;
  logic        irsp_valid_reg, irsp_valid_next;
  logic [31:0] irsp_data_reg,  irsp_data_next;
  logic        drsp_valid_reg, drsp_valid_next;
  logic [31:0] drsp_data_reg,  drsp_data_next;

  logic is_idle;
  logic data_prio;
  logic fetch_ok;
  logic grant_d;
  logic grant_i;
  logic accept_d;
  logic accept_i;

  // Grant selection: data first while under the starvation limit, then an
  // unflushed fetch, then data as the fallback when fetch cannot go.
  always_comb begin
    is_idle   = (state_reg == ST_IDLE);
    data_prio = dreq_valid_i && (starve_cnt_reg < STARVE_MAX);
    fetch_ok  = ireq_valid_i && !flush_i;
    grant_d   = data_prio || (dreq_valid_i && !fetch_ok);
    grant_i   = !data_prio && fetch_ok;
    accept_d  = is_idle && grant_d;
    accept_i  = is_idle && grant_i;
  end

  assign dreq_ready_o = accept_d;
  assign ireq_ready_o = accept_i;

  // Next-state logic for the FSM, bus request, starvation counter and
  // response registers. Response valids are single-cycle pulses.
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    drop_next       = drop_reg;
    bus_next        = bus_reg;
    mem_req_next    = mem_req_reg;
    irsp_valid_next = 1'b0;
    irsp_data_next  = irsp_data_reg;
    drsp_valid_next = 1'b0;
    drsp_data_next  = drsp_data_reg;

    case (state_reg)
      ST_IDLE: begin
        drop_next = 1'b0;
        if (accept_d) begin
          bus_next.addr  = dreq_addr_i;
          bus_next.wdata = dreq_wdata_i;
          bus_next.write = dreq_write_i;
          bus_next.width = dreq_width_i;
          mem_req_next   = 1'b1;
          state_next     = ST_BUSY_D;
          // Only count data grants that actually made a fetch wait.
          if (ireq_valid_i) begin
            if (starve_cnt_reg < STARVE_MAX) begin
              starve_cnt_next = starve_cnt_reg + 4'd1;
            end else begin
              starve_cnt_next = STARVE_MAX;
            end
          end else begin
            starve_cnt_next = 4'd0;
          end
        end else if (accept_i) begin
          bus_next        = fetch_req(ireq_addr_i);
          mem_req_next    = 1'b1;
          state_next      = ST_BUSY_I;
          starve_cnt_next = 4'd0;
        end
      end

      ST_BUSY_I: begin
        if (flush_i) begin
          drop_next = 1'b1;
        end
        if (mem_ack_i) begin
          irsp_data_next  = mem_rdata_i;
          // A flush seen at any point of the fetch, ack cycle included,
          // kills its response.
          irsp_valid_next = !(drop_reg || flush_i);
          mem_req_next    = 1'b0;
          drop_next       = 1'b0;
          state_next      = ST_IDLE;
        end
      end

      ST_BUSY_D: begin
        if (mem_ack_i) begin
          drsp_data_next  = bus_reg.write ? 32'd0 : mem_rdata_i;
          drsp_valid_next = 1'b1;
          mem_req_next    = 1'b0;
          state_next      = ST_IDLE;
        end
      end

      default: begin
        mem_req_next = 1'b0;
        drop_next    = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any transaction and clears every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      starve_cnt_reg <= 4'd0;
      drop_reg       <= 1'b0;
      bus_reg        <= '0;
      mem_req_reg    <= 1'b0;
      irsp_valid_reg <= 1'b0;
      irsp_data_reg  <= 32'd0;
      drsp_valid_reg <= 1'b0;
      drsp_data_reg  <= 32'd0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      drop_reg       <= drop_next;
      bus_reg        <= bus_next;
      mem_req_reg    <= mem_req_next;
      irsp_valid_reg <= irsp_valid_next;
      irsp_data_reg  <= irsp_data_next;
      drsp_valid_reg <= drsp_valid_next;
      drsp_data_reg  <= drsp_data_next;
    end
  end

  assign mem_req_o    = mem_req_reg;
  assign mem_addr_o   = bus_reg.addr;
  assign mem_wdata_o  = bus_reg.wdata;
  assign mem_write_o  = bus_reg.write;
  assign mem_width_o  = bus_reg.width;
  assign irsp_valid_o = irsp_valid_reg;
  assign irsp_data_o  = irsp_data_reg;
  assign drsp_valid_o = drsp_valid_reg;
  assign drsp_data_o  = drsp_data_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle table of inputs and
// expected outputs, plus hand-written starvation and reset sequences.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ireq_valid_i;
  logic        ireq_ready_o;
  logic [31:0] ireq_addr_i;
  logic        irsp_valid_o;
  logic [31:0] irsp_data_o;
  logic        flush_i;
  logic        dreq_valid_i;
  logic        dreq_ready_o;
  logic [31:0] dreq_addr_i;
  logic [31:0] dreq_wdata_i;
  logic        dreq_write_i;
  logic [1:0]  dreq_width_i;
  logic        drsp_valid_o;
  logic [31:0] drsp_data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_write_o;
  logic [1:0]  mem_width_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ireq_valid_i (ireq_valid_i),
    .ireq_ready_o (ireq_ready_o),
    .ireq_addr_i  (ireq_addr_i),
    .irsp_valid_o (irsp_valid_o),
    .irsp_data_o  (irsp_data_o),
    .flush_i      (flush_i),
    .dreq_valid_i (dreq_valid_i),
    .dreq_ready_o (dreq_ready_o),
    .dreq_addr_i  (dreq_addr_i),
    .dreq_wdata_i (dreq_wdata_i),
    .dreq_write_i (dreq_write_i),
    .dreq_width_i (dreq_width_i),
    .drsp_valid_o (drsp_valid_o),
    .drsp_data_o  (drsp_data_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_write_o  (mem_write_o),
    .mem_width_o  (mem_width_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        dwr;
    logic [1:0]  dwi;
    logic        fl;
    logic        ack;
    logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic        ir;
    logic        dr;
    logic        isv;
    logic [31:0] isd;
    logic        dsv;
    logic [31:0] dsd;
    logic        mq;
    logic [31:0] ma;
    logic        mw;
    logic [1:0]  mwi;
    logic [31:0] mwd;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs [0:63];
  int   nv = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic in_t inp(logic iv, logic [31:0] ia, logic dv, logic [31:0] da, logic [31:0] dwd,
                              logic dwr, logic [1:0] dwi, logic fl, logic ack, logic [31:0] rd);
    in_t r;
    r = {iv, ia, dv, da, dwd, dwr, dwi, fl, ack, rd};
    return r;
  endfunction

  function automatic out_t outp(logic ir, logic dr, logic isv, logic [31:0] isd, logic dsv, logic [31:0] dsd,
                                logic mq, logic [31:0] ma, logic mw, logic [1:0] mwi, logic [31:0] mwd);
    out_t r;
    r = {ir, dr, isv, isd, dsv, dsd, mq, ma, mw, mwi, mwd};
    return r;
  endfunction

  function automatic out_t cur_out();
    out_t r;
    r = {ireq_ready_o, dreq_ready_o, irsp_valid_o, irsp_data_o, drsp_valid_o, drsp_data_o,
         mem_req_o, mem_addr_o, mem_write_o, mem_width_o, mem_wdata_o};
    return r;
  endfunction

  task automatic row(input in_t i, input out_t o);
    vecs[nv] = {i, o};
    nv++;
  endtask

  task automatic drive(input in_t i);
    ireq_valid_i = i.iv;
    ireq_addr_i  = i.ia;
    dreq_valid_i = i.dv;
    dreq_addr_i  = i.da;
    dreq_wdata_i = i.dwd;
    dreq_write_i = i.dwr;
    dreq_width_i = i.dwi;
    flush_i      = i.fl;
    mem_ack_i    = i.ack;
    mem_rdata_i  = i.rd;
  endtask

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  in_t  idle_in;
  logic [7:0] grants [0:5];
  logic [7:0] exp_grants [0:5];
  int   ng;

  initial begin
    idle_in = '0;
    // ---- per-cycle table: inputs applied, outputs expected in the same cycle
    // fetch only, ack one cycle after mem_req rises
    row(idle_in, outp(0,0,0,32'h0,0,32'h0,0,32'h0,0,2'd0,32'h0));
    row(inp(1,32'h100,0,0,0,0,0,0,0,0), outp(1,0,0,32'h0,0,32'h0,0,32'h0,0,2'd0,32'h0));
    row(idle_in, outp(0,0,0,32'h0,0,32'h0,1,32'h100,0,2'd2,32'h0));
    row(inp(0,0,0,0,0,0,0,0,1,32'h00500093), outp(0,0,0,32'h0,0,32'h0,1,32'h100,0,2'd2,32'h0));
    row(inp(1,32'h104,0,0,0,0,0,0,0,0), outp(1,0,1,32'h00500093,0,32'h0,0,32'h100,0,2'd2,32'h0));
    row(inp(0,0,0,0,0,0,0,0,1,32'h11111111), outp(0,0,0,32'h00500093,0,32'h0,1,32'h104,0,2'd2,32'h0));
    row(idle_in, outp(0,0,1,32'h11111111,0,32'h0,0,32'h104,0,2'd2,32'h0));
    // simultaneous fetch and load: data first, fetch after the drsp pulse
    row(inp(1,32'h108,1,32'h2000,0,0,2'd2,0,0,0), outp(0,1,0,32'h11111111,0,32'h0,0,32'h104,0,2'd2,32'h0));
    row(inp(1,32'h108,0,0,0,0,0,0,1,32'hCAFEF00D), outp(0,0,0,32'h11111111,0,32'h0,1,32'h2000,0,2'd2,32'h0));
    row(inp(1,32'h108,0,0,0,0,0,0,0,0), outp(1,0,0,32'h11111111,1,32'hCAFEF00D,0,32'h2000,0,2'd2,32'h0));
    row(inp(0,0,0,0,0,0,0,0,1,32'h22222222), outp(0,0,0,32'h11111111,0,32'hCAFEF00D,1,32'h108,0,2'd2,32'h0));
    row(idle_in, outp(0,0,1,32'h22222222,0,32'hCAFEF00D,0,32'h108,0,2'd2,32'h0));
    // byte store with a 3-cycle-delayed ack
    row(inp(0,0,1,32'h2004,32'hDEADBEEF,1,2'd0,0,0,0), outp(0,1,0,32'h22222222,0,32'hCAFEF00D,0,32'h108,0,2'd2,32'h0));
    for (int k = 0; k < 3; k++)
      row(idle_in, outp(0,0,0,32'h22222222,0,32'hCAFEF00D,1,32'h2004,1,2'd0,32'hDEADBEEF));
    row(inp(0,0,0,0,0,0,0,0,1,32'h55555555), outp(0,0,0,32'h22222222,0,32'hCAFEF00D,1,32'h2004,1,2'd0,32'hDEADBEEF));
    row(idle_in, outp(0,0,0,32'h22222222,1,32'h0,0,32'h2004,1,2'd0,32'hDEADBEEF));
    row(idle_in, outp(0,0,0,32'h22222222,0,32'h0,0,32'h2004,1,2'd0,32'hDEADBEEF));
    // flush mid BUSY_I
    row(inp(1,32'h200,0,0,0,0,0,0,0,0), outp(1,0,0,32'h22222222,0,32'h0,0,32'h2004,1,2'd0,32'hDEADBEEF));
    row(inp(0,0,0,0,0,0,0,1,0,0), outp(0,0,0,32'h22222222,0,32'h0,1,32'h200,0,2'd2,32'h0));
    row(inp(0,0,0,0,0,0,0,0,1,32'h33333333), outp(0,0,0,32'h22222222,0,32'h0,1,32'h200,0,2'd2,32'h0));
    row(idle_in, outp(0,0,0,32'h33333333,0,32'h0,0,32'h200,0,2'd2,32'h0));
    // flush in the ack cycle
    row(inp(1,32'h204,0,0,0,0,0,0,0,0), outp(1,0,0,32'h33333333,0,32'h0,0,32'h200,0,2'd2,32'h0));
    row(inp(0,0,0,0,0,0,0,1,1,32'h44444444), outp(0,0,0,32'h33333333,0,32'h0,1,32'h204,0,2'd2,32'h0));
    // flush in IDLE forces fetch ready low
    row(inp(1,32'h208,0,0,0,0,0,1,0,0), outp(0,0,0,32'h44444444,0,32'h0,0,32'h204,0,2'd2,32'h0));
    // next fetch returns normally
    row(inp(1,32'h208,0,0,0,0,0,0,0,0), outp(1,0,0,32'h44444444,0,32'h0,0,32'h204,0,2'd2,32'h0));
    row(inp(0,0,0,0,0,0,0,0,1,32'h66666666), outp(0,0,0,32'h44444444,0,32'h0,1,32'h208,0,2'd2,32'h0));
    row(idle_in, outp(0,0,1,32'h66666666,0,32'h0,0,32'h208,0,2'd2,32'h0));
    // ack in IDLE is ignored
    row(inp(0,0,0,0,0,0,0,0,1,32'h77777777), outp(0,0,0,32'h66666666,0,32'h0,0,32'h208,0,2'd2,32'h0));
    row(idle_in, outp(0,0,0,32'h66666666,0,32'h0,0,32'h208,0,2'd2,32'h0));

    // ---- reset
    rst_n = 1'b0;
    drive(idle_in);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < nv; k++) begin
      @(negedge clk);
      drive(vecs[k].i);
      #1;
      chk($sformatf("row%0d", k), 160'(cur_out()), 160'(vecs[k].o));
    end

    // ---- starvation: data and fetch both held valid, zero-wait memory
    exp_grants[0] = "D"; exp_grants[1] = "D"; exp_grants[2] = "D";
    exp_grants[3] = "D"; exp_grants[4] = "I"; exp_grants[5] = "D";
    ng = 0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      @(negedge clk);
      drive(inp(1,32'h300,1,32'h3000,0,0,2'd2,0,0,0));
      #1;
      if (dreq_ready_o) begin
        grants[ng] = "D";
        ng++;
      end else if (ireq_ready_o) begin
        grants[ng] = "I";
        ng++;
      end
      mem_ack_i   = mem_req_o;
      mem_rdata_i = 32'(c);
    end
    chk("starve_grant_count", 160'(ng), 160'(6));
    for (int k = 0; k < 6; k++) begin
      if (k < ng) chk($sformatf("starve_grant%0d", k), 160'(grants[k]), 160'(exp_grants[k]));
    end

    // ---- asynchronous reset in the middle of a data transaction
    @(negedge clk);
    drive(idle_in);
    #1;
    chk("busy_d_before_reset", 160'({mem_req_o, mem_addr_o}), 160'({1'b1, 32'h3000}));
    #1;
    rst_n = 1'b0;
    #1;
    chk("outputs_in_reset", 160'(cur_out()), 160'(0));
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack_i = 1'b0;
    rst_n     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("after_reset%0d", k), 160'({drsp_valid_o, irsp_valid_o, mem_req_o}), 160'(0));
      @(negedge clk);
    end
    // fresh load after reset
    drive(inp(0,0,1,32'h4000,0,0,2'd2,0,0,0));
    #1;
    chk("post_reset_dready", 160'(dreq_ready_o), 160'(1));
    @(negedge clk);
    drive(inp(0,0,0,0,0,0,0,0,1,32'h89ABCDEF));
    #1;
    chk("post_reset_bus", 160'({mem_req_o, mem_addr_o, mem_write_o}), 160'({1'b1, 32'h4000, 1'b0}));
    @(negedge clk);
    drive(idle_in);
    #1;
    chk("post_reset_drsp", 160'({drsp_valid_o, drsp_data_o}), 160'({1'b1, 32'h89ABCDEF}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single-ported memory bus between instruction fetch and the execute stage's load/store port. Accepts one request at a time from either side over a valid/ready handshake, holds it on the bus until the memory acknowledges, and returns the read data or store completion to the originating side. Data requests have priority, with a starvation limit that guarantees fetch progress. Taken jumps can flush an in-flight fetch.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while a fetch is pending; range 1..15.
- `clk` in 1: single clock; all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ireq_valid_i` in 1, `ireq_ready_o` out 1, `ireq_addr_i` in 32: fetch request handshake and word address.
- `irsp_valid_o` out 1, `irsp_data_o` out 32: one-cycle fetch response pulse and instruction word.
- `flush_i` in 1: taken jump; kills the pending or in-flight fetch.
- `dreq_valid_i` in 1, `dreq_ready_o` out 1: data request handshake.
- `dreq_addr_i` in 32, `dreq_wdata_i` in 32, `dreq_write_i` in 1, `dreq_width_i` in 2: data address, store data, store flag, width (0 byte, 1 half, 2 word; funct3[1:0]).
- `drsp_valid_o` out 1, `drsp_data_o` out 32: one-cycle data response; raw load word, or 0 for a store.
- `mem_req_o` out 1, `mem_addr_o` out 32, `mem_wdata_o` out 32, `mem_write_o` out 1, `mem_width_o` out 2: memory bus request, held stable until acknowledged.
- `mem_ack_i` in 1, `mem_rdata_i` in 32: memory acknowledge and read data, valid in the ack cycle.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE grant selection:
  - Data wins if `dreq_valid_i` is high and `starve_cnt < STARVE_LIMIT`.
  - Otherwise fetch wins if `ireq_valid_i` is high and `flush_i` is low.
  - Otherwise data wins if it is valid.
- `dreq_ready_o` and `ireq_ready_o` are combinational. Each is high only in IDLE for the side that would be granted. `ireq_ready_o` is forced low while `flush_i` is high.
- Acceptance: a valid&ready handshake registers the request into the `mem_*` outputs, sets `mem_req_o`, and moves to BUSY_I or BUSY_D. Fetch grants drive `mem_write_o`=0 and `mem_width_o`=2.
- BUSY_x: `mem_*` is held. On `mem_ack_i`:
  - Register `mem_rdata_i` into the response data output and pulse the response valid next cycle.
  - Clear `mem_req_o` and return to IDLE.
  - Stores pulse `drsp_valid_o` with `drsp_data_o`=0.
- Starvation counter, `starve_cnt` (4 bits):
  - +1 on a data grant while `ireq_valid_i` is high.
  - Cleared on every fetch grant.
  - Cleared on a data grant while `ireq_valid_i` is low.
  - Saturates at `STARVE_LIMIT`.
- Flush:
  - `flush_i` in BUSY_I, including the ack cycle, sets `drop`.
  - The fetch completes on the bus, but `irsp_valid_o` is suppressed for it.
  - `drop` clears on leaving BUSY_I.
  - `flush_i` has no effect on data transactions.
- Reset: state IDLE; `starve_cnt`=0; `drop`=0; every output is 0, including `mem_req_o`, `irsp_valid_o`, `drsp_valid_o` and all data/address outputs. Reset mid-transaction abandons it with no response.

## Timing
- Request accepted in cycle N: `mem_req_o` is high from N+1.
- Ack in cycle M ≥ N+1: the response pulse is in M+1, and the block is back in IDLE in M+1.
- The next request can be accepted in M+1. Back-to-back throughput is one transaction per 2 cycles with a zero-wait memory.
- Response pulses last exactly one cycle; there is no response backpressure, so consumers must always accept.
- `mem_ack_i` is ignored in IDLE.
- Requests arriving while BUSY see ready=0 and must be held by the requester.

## Structure
- Shared definitions include file (`mem_arb_def.v`), alongside the existing instruction defs:
  - State encodings IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2.
  - Width codes MEM_W_B=0, MEM_W_H=1, MEM_W_W=2.
- No sub-module; grant logic, FSM and counter live in one module of about 150–200 lines.

## Test plan
- Fetch only: `ireq` addr 0x100, ack one cycle after `mem_req_o` -> `mem_addr_o`=0x100; `irsp_valid_o` one cycle with `mem_rdata_i` 0x00500093; ready again the same cycle.
- Simultaneous `ireq` and `dreq` (load 0x2000, width 2) -> data granted first; fetch granted after the `drsp` pulse.
- Continuous `dreq` plus pending `ireq`, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 fetch grant, then data resumes.
- Store 0x2004 data 0xDEADBEEF width 0 -> `mem_write_o`=1, `mem_width_o`=0, `mem_wdata_o` held until a 3-cycle-delayed ack; `drsp_valid_o` pulse with `drsp_data_o`=0.
- `flush_i` pulse during BUSY_I, and separately in the ack cycle -> no `irsp_valid_o`; the next fetch returns normally.
- `rst_n` low mid-BUSY_D -> all outputs 0 asynchronously; after release, IDLE with no stale `drsp_valid_o`.
